// File: rtl/acs_survivor.sv
// Add-compare-select unit with survivor memory for a hard-decision Viterbi decoder.
// One trellis state is updated per cycle; a completed step is committed as one
// survivor column and the metrics are renormalised so their minimum is zero.
module acs_survivor #(
  parameter int unsigned M   = 2,
  parameter int unsigned D   = 6,
  parameter int unsigned PMW = 8,
  parameter logic [M:0]  G0  = 3'b111,
  parameter logic [M:0]  G1  = 3'b101
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         sym_valid,
  input  logic [1:0]   sym,
  input  logic         sym_last,
  output logic         sym_ready,
  output logic [2:0]   wr_ptr,
  output logic [M-1:0] s_end,
  output logic         tb_start,
  output logic         force_state0,
  input  logic [2:0]   tb_time,
  input  logic [M-1:0] tb_state,
  output logic         tb_surv_bit
);

  localparam int unsigned    S       = 1 << M;
  localparam logic [PMW-1:0] PM_INIT = {2'b01, {(PMW-2){1'b0}}};
  localparam logic [PMW-1:0] PM_MAX  = '1;
  localparam logic [2:0]     D_LAST  = 3'(D - 1);
  localparam logic [3:0]     D_FILL  = 4'(D);

  typedef enum logic [1:0] {IDLE, ACS, FIN} state_t;

  state_t         state;
  logic [M-1:0]   j;
  logic [1:0]     sym_q;
  logic           last_q;
  logic [3:0]     fill;
  logic [PMW-1:0] pm    [S];
  logic [PMW-1:0] pm_sh [S];
  logic [S-1:0]   stage;
  logic [S-1:0]   mem   [D];

  logic [M-1:0]   p0, p1;
  logic [M:0]     r0, r1;
  logic [1:0]     bm0, bm1;
  logic [PMW:0]   sum0, sum1;
  logic [PMW-1:0] cand0, cand1, best;
  logic           sel1;
  logic [PMW-1:0] pm_min;
  logic [M-1:0]   pm_arg;
  logic [2:0]     wp_next;
  logic [3:0]     fill_inc;

  // Branch metrics and compare-select for the state j being updated this cycle
  always_comb begin
    p0    = {1'b0, j[M-1:1]};
    p1    = {1'b1, j[M-1:1]};
    r0    = {p0, j[0]};
    r1    = {p1, j[0]};
    bm0   = {1'b0, sym_q[1] ^ (^(r0 & G0))} + {1'b0, sym_q[0] ^ (^(r0 & G1))};
    bm1   = {1'b0, sym_q[1] ^ (^(r1 & G0))} + {1'b0, sym_q[0] ^ (^(r1 & G1))};
    sum0  = {1'b0, pm[p0]} + {{(PMW-1){1'b0}}, bm0};
    sum1  = {1'b0, pm[p1]} + {{(PMW-1){1'b0}}, bm1};
    cand0 = sum0[PMW] ? PM_MAX : sum0[PMW-1:0];
    cand1 = sum1[PMW] ? PM_MAX : sum1[PMW-1:0];
    sel1  = (cand1 < cand0);
    best  = sel1 ? cand1 : cand0;
  end

  // Minimum and lowest-index argmin of the freshly computed metrics
  always_comb begin
    pm_min = pm_sh[0];
    pm_arg = '0;
    for (int unsigned i = 1; i < S; i++) begin
      if (pm_sh[i] < pm_min) begin
        pm_min = pm_sh[i];
        pm_arg = M'(i);
      end
    end
    wp_next  = (wr_ptr == D_LAST) ? 3'd0 : wr_ptr + 3'd1;
    fill_inc = (fill == D_FILL) ? D_FILL : fill + 4'd1;
  end

  // Sequencing: symbol acceptance, per-state ACS stepping, commit bookkeeping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      j            <= '0;
      sym_q        <= '0;
      last_q       <= 1'b0;
      sym_ready    <= 1'b1;
      wr_ptr       <= D_LAST;
      s_end        <= '0;
      tb_start     <= 1'b0;
      force_state0 <= 1'b0;
      fill         <= '0;
    end else begin
      tb_start     <= 1'b0;
      force_state0 <= 1'b0;
      case (state)
        IDLE: begin
          if (sym_valid && sym_ready) begin
            sym_q     <= sym;
            last_q    <= sym_last;
            j         <= '0;
            sym_ready <= 1'b0;
            state     <= ACS;
          end
        end
        ACS: begin
          j <= j + M'(1);
          if (j == '1) state <= FIN;
        end
        FIN: begin
          state     <= IDLE;
          sym_ready <= 1'b1;
          wr_ptr    <= wp_next;
          tb_start  <= (fill_inc == D_FILL) || last_q;
          if (last_q) begin
            s_end        <= '0;
            force_state0 <= 1'b1;
            fill         <= '0;
          end else begin
            s_end <= pm_arg;
            fill  <= fill_inc;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Path metrics: shadow writes during ACS, normalised swap (or frame restart) in FIN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < S; i++) begin
        pm[i]    <= (i == 0) ? '0 : PM_INIT;
        pm_sh[i] <= '0;
      end
      stage <= '0;
    end else begin
      if (state == ACS) begin
        pm_sh[j] <= best;
        stage[j] <= sel1;
      end else if (state == FIN) begin
        for (int unsigned i = 0; i < S; i++) begin
          if (last_q) pm[i] <= (i == 0) ? '0 : PM_INIT;
          else        pm[i] <= pm_sh[i] - pm_min;
        end
      end
    end
  end

  // Survivor memory: one column committed per completed step
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < D; i++) mem[i] <= '0;
    end else if (state == FIN) begin
      mem[wp_next] <= stage;
    end
  end

  // Combinational survivor read; out-of-range columns read as zero
  always_comb begin
    tb_surv_bit = 1'b0;
    if ({1'b0, tb_time} < D_FILL) tb_surv_bit = mem[tb_time][tb_state];
  end

endmodule

// File: tb/tb_acs_survivor.sv
// Randomised self-checking bench for acs_survivor against a trellis-level model.
module tb_acs_survivor;

  localparam int M     = 2;
  localparam int S     = 4;
  localparam int D     = 6;
  localparam int PMW   = 8;
  localparam int G0    = 7;
  localparam int G1    = 5;
  localparam int PMAX  = 255;
  localparam int PINIT = 64;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         sym_valid = 1'b0;
  logic [1:0]   sym = '0;
  logic         sym_last = 1'b0;
  logic         sym_ready;
  logic [2:0]   wr_ptr;
  logic [M-1:0] s_end;
  logic         tb_start;
  logic         force_state0;
  logic [2:0]   tb_time = '0;
  logic [M-1:0] tb_state = '0;
  logic         tb_surv_bit;

  acs_survivor #(.M(M), .D(D), .PMW(PMW), .G0(3'b111), .G1(3'b101)) dut (
    .clk(clk), .rst_n(rst_n), .sym_valid(sym_valid), .sym(sym), .sym_last(sym_last),
    .sym_ready(sym_ready), .wr_ptr(wr_ptr), .s_end(s_end), .tb_start(tb_start),
    .force_state0(force_state0), .tb_time(tb_time), .tb_state(tb_state),
    .tb_surv_bit(tb_surv_bit)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int n_pulse = 0;

  always @(negedge clk) if (tb_start === 1'b1) n_pulse++;

  int m_pm [S];
  int m_mem [D][S];
  int m_wp, m_fill, m_send;
  bit m_tbs, m_force;

  function automatic int parity(input int x);
    return $countones(x) & 1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < S; i++) m_pm[i] = (i == 0) ? 0 : PINIT;
    for (int t = 0; t < D; t++) for (int i = 0; i < S; i++) m_mem[t][i] = 0;
    m_wp = D - 1; m_fill = 0; m_send = 0; m_tbs = 0; m_force = 0;
  endtask

  // One trellis step: every state keeps the cheaper of its two incoming branches
  task automatic model_step(input int s, input bit last);
    int nxt [S];
    int col [S];
    int p, r, e, c, mn, arg;
    for (int ns = 0; ns < S; ns++) begin
      for (int b = 0; b < 2; b++) begin
        p = b * (S / 2) + ns / 2;
        r = p * 2 + ns % 2;
        e = parity(r & G0) * 2 + parity(r & G1);
        c = m_pm[p] + $countones(e ^ s);
        if (c > PMAX) c = PMAX;
        if (b == 0 || c < nxt[ns]) begin
          nxt[ns] = c;
          col[ns] = b;
        end
      end
    end
    mn = nxt[0]; arg = 0;
    for (int i = 1; i < S; i++) if (nxt[i] < mn) begin mn = nxt[i]; arg = i; end
    m_wp = (m_wp == D - 1) ? 0 : m_wp + 1;
    for (int i = 0; i < S; i++) m_mem[m_wp][i] = col[i];
    m_fill  = (m_fill < D) ? m_fill + 1 : D;
    m_tbs   = (m_fill >= D) || last;
    m_force = last;
    if (last) begin
      for (int i = 0; i < S; i++) m_pm[i] = (i == 0) ? 0 : PINIT;
      m_fill = 0; m_send = 0;
    end else begin
      for (int i = 0; i < S; i++) m_pm[i] = nxt[i] - mn;
      m_send = arg;
    end
  endtask

  // Offer a symbol, then count cycles (accept cycle = 1) until the column commits
  task automatic drive_symbol(input int s, input bit last, output int lat);
    logic [2:0] wp0;
    lat = -1;
    for (int k = 0; k < 20 && sym_ready !== 1'b1; k++) begin @(posedge clk); #1; end
    if (sym_ready !== 1'b1) return;
    wp0 = wr_ptr;
    sym_valid = 1'b1; sym = 2'(s); sym_last = last;
    @(posedge clk); #1;
    sym_valid = 1'b0; sym_last = 1'b0;
    for (int k = 2; k < 20; k++) begin
      @(posedge clk); #1;
      if (wr_ptr !== wp0) begin lat = k; break; end
    end
    model_step(s, last);
  endtask

  task automatic read_bit(input int t, input int st, output logic b);
    tb_time = 3'(t); tb_state = 2'(st);
    #1;
    b = tb_surv_bit;
  endtask

  task automatic apply_reset();
    #2 rst_n = 1'b0;
    #2 rst_n = 1'b1;
    model_reset();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    logic b;
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    n_tests++; if (sym_ready !== 1'b1) begin n_fail++; $display("FAIL rst_sym_ready: got %0d expected 1", sym_ready); end
    n_tests++; if (wr_ptr !== 3'd5) begin n_fail++; $display("FAIL rst_wr_ptr: got %0d expected 5", wr_ptr); end
    n_tests++; if (s_end !== 2'd0) begin n_fail++; $display("FAIL rst_s_end: got %0d expected 0", s_end); end
    n_tests++; if (tb_start !== 1'b0 || force_state0 !== 1'b0) begin n_fail++; $display("FAIL rst_pulses: got %0d/%0d expected 0/0", tb_start, force_state0); end
    n_tests++; if (dut.fill !== 4'd0) begin n_fail++; $display("FAIL rst_fill: got %0d expected 0", dut.fill); end
    for (int i = 0; i < S; i++) begin
      n_tests++; if (dut.pm[i] !== 8'((i == 0) ? 0 : PINIT)) begin n_fail++; $display("FAIL rst_pm%0d: got %0d expected %0d", i, dut.pm[i], (i == 0) ? 0 : PINIT); end
    end
    for (int t = 0; t < D; t++) for (int st = 0; st < S; st++) begin
      read_bit(t, st, b);
      n_tests++; if (b !== 1'b0) begin n_fail++; $display("FAIL rst_mem[%0d][%0d]: got %0d expected 0", t, st, b); end
    end
    @(negedge clk) rst_n = 1'b1;
    model_reset();
    @(posedge clk); #1;
  endtask

  task automatic test_zero_stream();
    int lat, p0;
    apply_reset();
    p0 = n_pulse;
    for (int i = 0; i < 6; i++) begin
      drive_symbol(0, 0, lat);
      n_tests++; if (lat != S + 2) begin n_fail++; $display("FAIL zero_latency%0d: got %0d expected %0d", i, lat, S + 2); end
      n_tests++; if (tb_start !== (i == 5)) begin n_fail++; $display("FAIL zero_tb_start%0d: got %0d expected %0d", i, tb_start, i == 5); end
      n_tests++; if (force_state0 !== 1'b0) begin n_fail++; $display("FAIL zero_force%0d: got %0d expected 0", i, force_state0); end
      n_tests++; if (wr_ptr !== 3'(i)) begin n_fail++; $display("FAIL zero_wr_ptr%0d: got %0d expected %0d", i, wr_ptr, i); end
      n_tests++; if (s_end !== 2'd0) begin n_fail++; $display("FAIL zero_s_end%0d: got %0d expected 0", i, s_end); end
      n_tests++; if (dut.pm[0] !== 8'd0) begin n_fail++; $display("FAIL zero_pm0_%0d: got %0d expected 0", i, dut.pm[0]); end
    end
    @(posedge clk); #1;
    n_tests++; if (tb_start !== 1'b0) begin n_fail++; $display("FAIL zero_tb_start_drop: got %0d expected 0", tb_start); end
    n_tests++; if (n_pulse - p0 != 1) begin n_fail++; $display("FAIL zero_pulse_count: got %0d expected 1", n_pulse - p0); end
  endtask

  task automatic test_single_ones();
    int lat;
    logic b;
    apply_reset();
    drive_symbol(3, 0, lat);
    n_tests++; if (s_end !== 2'd1) begin n_fail++; $display("FAIL ones_s_end: got %0d expected 1", s_end); end
    n_tests++; if (dut.pm[0] !== 8'd2) begin n_fail++; $display("FAIL ones_pm0: got %0d expected 2", dut.pm[0]); end
    n_tests++; if (dut.pm[1] !== 8'd0) begin n_fail++; $display("FAIL ones_pm1: got %0d expected 0", dut.pm[1]); end
    n_tests++; if (dut.pm[2] !== 8'd65) begin n_fail++; $display("FAIL ones_pm2: got %0d expected 65", dut.pm[2]); end
    read_bit(0, 1, b);
    n_tests++; if (b !== 1'b0) begin n_fail++; $display("FAIL ones_mem01: got %0d expected 0", b); end
  endtask

  task automatic test_wrap();
    int lat;
    int first [S];
    logic b;
    apply_reset();
    for (int i = 0; i < 7; i++) begin
      drive_symbol($urandom_range(0, 3), 0, lat);
      if (i == 0) for (int st = 0; st < S; st++) first[st] = m_mem[0][st];
    end
    n_tests++; if (wr_ptr !== 3'd0) begin n_fail++; $display("FAIL wrap_wr_ptr: got %0d expected 0", wr_ptr); end
    n_tests++; if (tb_start !== 1'b1) begin n_fail++; $display("FAIL wrap_tb_start: got %0d expected 1", tb_start); end
    for (int st = 0; st < S; st++) begin
      read_bit(0, st, b);
      n_tests++; if (b !== 1'(m_mem[0][st])) begin n_fail++; $display("FAIL wrap_col0_%0d: got %0d expected %0d", st, b, m_mem[0][st]); end
      if (m_mem[0][st] != first[st]) begin
        n_tests++; if (b === 1'(first[st])) begin n_fail++; $display("FAIL wrap_stale_%0d: got %0d expected %0d", st, b, m_mem[0][st]); end
      end
    end
    for (int t = 6; t < 8; t++) begin
      read_bit(t, $urandom_range(0, 3), b);
      n_tests++; if (b !== 1'b0) begin n_fail++; $display("FAIL wrap_oob%0d: got %0d expected 0", t, b); end
    end
  endtask

  task automatic test_last();
    int lat;
    apply_reset();
    for (int i = 0; i < 3; i++) drive_symbol($urandom_range(0, 3), 0, lat);
    drive_symbol($urandom_range(0, 3), 1, lat);
    n_tests++; if (tb_start !== 1'b1) begin n_fail++; $display("FAIL last_tb_start: got %0d expected 1", tb_start); end
    n_tests++; if (force_state0 !== 1'b1) begin n_fail++; $display("FAIL last_force: got %0d expected 1", force_state0); end
    n_tests++; if (s_end !== 2'd0) begin n_fail++; $display("FAIL last_s_end: got %0d expected 0", s_end); end
    n_tests++; if (dut.fill !== 4'd0) begin n_fail++; $display("FAIL last_fill: got %0d expected 0", dut.fill); end
    for (int i = 0; i < S; i++) begin
      n_tests++; if (dut.pm[i] !== 8'((i == 0) ? 0 : PINIT)) begin n_fail++; $display("FAIL last_pm%0d: got %0d expected %0d", i, dut.pm[i], (i == 0) ? 0 : PINIT); end
    end
    @(posedge clk); #1;
    n_tests++; if (tb_start !== 1'b0 || force_state0 !== 1'b0) begin n_fail++; $display("FAIL last_drop: got %0d/%0d expected 0/0", tb_start, force_state0); end
    drive_symbol($urandom_range(0, 3), 0, lat);
    n_tests++; if (dut.fill !== 4'd1) begin n_fail++; $display("FAIL last_refill: got %0d expected 1", dut.fill); end
    n_tests++; if (tb_start !== 1'b0) begin n_fail++; $display("FAIL last_after_tb_start: got %0d expected 0", tb_start); end
  endtask

  task automatic test_abort();
    int lat;
    logic b;
    apply_reset();
    drive_symbol(1, 0, lat);
    drive_symbol(2, 0, lat);
    sym_valid = 1'b1; sym = 2'(3); sym_last = 1'b0;
    @(posedge clk); #1;
    sym_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    n_tests++; if (sym_ready !== 1'b1) begin n_fail++; $display("FAIL abort_sym_ready: got %0d expected 1", sym_ready); end
    n_tests++; if (wr_ptr !== 3'd5) begin n_fail++; $display("FAIL abort_wr_ptr: got %0d expected 5", wr_ptr); end
    model_reset();
    for (int t = 0; t < D; t++) for (int st = 0; st < S; st++) begin
      read_bit(t, st, b);
      n_tests++; if (b !== 1'b0) begin n_fail++; $display("FAIL abort_mem[%0d][%0d]: got %0d expected 0", t, st, b); end
    end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    drive_symbol(3, 0, lat);
    n_tests++; if (lat != S + 2) begin n_fail++; $display("FAIL abort_next_latency: got %0d expected %0d", lat, S + 2); end
    n_tests++; if (wr_ptr !== 3'd0) begin n_fail++; $display("FAIL abort_next_wr_ptr: got %0d expected 0", wr_ptr); end
    n_tests++; if (s_end !== 2'(m_send)) begin n_fail++; $display("FAIL abort_next_s_end: got %0d expected %0d", s_end, m_send); end
  endtask

  task automatic test_random();
    int lat, s, mn;
    bit last;
    logic b;
    apply_reset();
    for (int n = 0; n < 200; n++) begin
      for (int g = $urandom_range(0, 2); g > 0; g--) begin @(posedge clk); #1; end
      s = $urandom_range(0, 3);
      last = ($urandom_range(0, 31) == 0);
      drive_symbol(s, last, lat);
      n_tests++; if (lat != S + 2) begin n_fail++; $display("FAIL rnd%0d_latency: got %0d expected %0d", n, lat, S + 2); end
      n_tests++; if (tb_start !== m_tbs) begin n_fail++; $display("FAIL rnd%0d_tb_start: got %0d expected %0d", n, tb_start, m_tbs); end
      n_tests++; if (force_state0 !== m_force) begin n_fail++; $display("FAIL rnd%0d_force: got %0d expected %0d", n, force_state0, m_force); end
      n_tests++; if (wr_ptr !== 3'(m_wp)) begin n_fail++; $display("FAIL rnd%0d_wr_ptr: got %0d expected %0d", n, wr_ptr, m_wp); end
      n_tests++; if (s_end !== 2'(m_send)) begin n_fail++; $display("FAIL rnd%0d_s_end: got %0d expected %0d", n, s_end, m_send); end
      n_tests++; if (dut.fill !== 4'(m_fill)) begin n_fail++; $display("FAIL rnd%0d_fill: got %0d expected %0d", n, dut.fill, m_fill); end
      mn = PMAX;
      for (int i = 0; i < S; i++) begin
        if (int'(dut.pm[i]) < mn) mn = int'(dut.pm[i]);
        n_tests++; if (dut.pm[i] !== 8'(m_pm[i])) begin n_fail++; $display("FAIL rnd%0d_pm%0d: got %0d expected %0d", n, i, dut.pm[i], m_pm[i]); end
      end
      n_tests++; if (mn != 0) begin n_fail++; $display("FAIL rnd%0d_pm_min: got %0d expected 0", n, mn); end
      for (int st = 0; st < S; st++) begin
        read_bit(m_wp, st, b);
        n_tests++; if (b !== 1'(m_mem[m_wp][st])) begin n_fail++; $display("FAIL rnd%0d_surv%0d: got %0d expected %0d", n, st, b, m_mem[m_wp][st]); end
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_zero_stream();
    test_single_ones();
    test_wrap();
    test_last();
    test_abort();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: got no completion expected finish");
    $fatal(1, "simulation time limit");
  end

endmodule

// File: doc/acs_survivor.md
ACS_SURVIVOR -- requirements
Module: acs_survivor

Interface
REQ-001 SHALL have parameters: M, default 2, code memory (states S = 2^M); D, default 6, survivor depth in columns; PMW, default 8, path-metric width; G0, default 3'b111, and G1, default 3'b101, (M+1)-bit generator polynomials, where bit 0 taps the current input.
REQ-002 SHALL have ports, clock and reset first:
- clk  in  1  sole clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- sym_valid  in  1  received symbol present.
- sym  in  2  hard-decision pair {c0,c1}; c0 is the MSB.
- sym_last  in  1  qualifies sym; marks the final symbol of a terminated frame.
- sym_ready  out  1  block can accept a symbol.
- wr_ptr  out  3  index of the most recently committed survivor column.
- s_end  out  M  best (minimum-metric) state after the last committed step.
- tb_start  out  1  one-cycle traceback trigger.
- force_state0  out  1  one-cycle pulse, coincident with tb_start, on a terminated frame.
- tb_time  in  3  survivor column to read.
- tb_state  in  M  state index within that column.
- tb_surv_bit  out  1  survivor bit at [tb_time][tb_state].

Function
REQ-003 SHALL accept a symbol on a rising edge where sym_valid=1 and sym_ready=1, latching sym and sym_last.
REQ-004 SHALL use a 3-state FSM:
- IDLE: sym_ready=1; on accept, go to ACS with j=0.
- ACS: one state j per cycle, j=0..S-1; after j=S-1, go to FIN.
- FIN: one cycle; then return to IDLE.
REQ-005 SHALL hold sym_ready=0 outside IDLE; throughput is one symbol per S+2 cycles.
REQ-006 SHALL encode the trellis as follows, where LSB is the newest bit:
- next state ns = {p[M-2:0],u}.
- predecessors of ns are p0={0,ns[M-1:1]} and p1={1,ns[M-1:1]}.
- branch register r={p,u}; expected output c0=^(r&G0), c1=^(r&G1).
REQ-007 SHALL compute the branch metric as the Hamming distance between sym and the expected {c0,c1}, giving 0..2.
REQ-008 SHALL form candidates pm[p0]+bm and pm[p1]+bm, each saturating at 2^PMW-1; SHALL select p1 only if strictly smaller (ties choose p0).
REQ-009 SHALL record the survivor bit for ns as the MSB of the chosen predecessor (0 for p0, 1 for p1), in a staging column.
REQ-010 SHALL write new metrics to a shadow array during ACS, so that every ACS reads only the previous step's metrics.
REQ-011 SHALL perform the following in FIN:
- swap shadow metrics into pm, normalized by subtracting their minimum (minimum becomes 0).
- commit the staging column to mem[wp_next], where wp_next=(wr_ptr==D-1)?0:wr_ptr+1.
- set wr_ptr=wp_next.
- set s_end=argmin, lowest index on ties.
REQ-012 SHALL increment a fill counter, saturating at D, on each commit.
REQ-013 SHALL assert tb_start for exactly the cycle after FIN, when the fill counter is at least D or the latched sym_last=1.
REQ-014 SHALL, when the latched sym_last=1: override s_end to 0, assert force_state0 with tb_start, reset all pm to their initial values, and clear the fill counter.
REQ-015 SHALL drive tb_surv_bit combinationally from mem[tb_time][tb_state]; SHALL return 0 for tb_time>=D; a read of the column being committed returns the pre-edge contents.
REQ-016 SHALL keep wr_ptr, s_end and memory contents stable except at the FIN edge.

Reset
REQ-017 SHALL, while rst_n=0, immediately force: FSM=IDLE, sym_ready=1, wr_ptr=D-1, s_end=0, tb_start=0, force_state0=0, fill counter=0.
REQ-018 SHALL reset pm[0]=0 and all other pm to 2^(PMW-2), and clear all survivor memory to 0.
REQ-019 SHALL abort any in-progress symbol on reset mid-operation; the aborted symbol is never committed.

Verification
REQ-020 SHALL cover: after reset, 6 symbols of sym=00 -> each commits S+2 cycles after accept; wr_ptr steps 0..5; s_end=0; pm[0]=0; tb_start high once, in the cycle after the 6th FIN.
REQ-021 SHALL cover: after reset, one sym=11 -> s_end=1, mem[0][1]=0, normalized pm[0]=2, pm[1]=0.
REQ-022 SHALL cover: 7 accepted symbols -> wr_ptr wraps 5->0; reading tb_time=0 returns the 7th column and no longer the 1st; tb_time=6 reads 0.
REQ-023 SHALL cover: a symbol with sym_last=1 -> s_end=0, force_state0 and tb_start both high for one cycle, pm back to reset values, fill counter 0.
REQ-024 SHALL cover: rst_n low during ACS (j=2) -> sym_ready=1 and wr_ptr=D-1 before the next edge; memory unchanged by the aborted symbol.
REQ-025 SHALL cover: 200 random symbols -> after every FIN, minimum pm=0, no pm exceeds 2^PMW-1, and survivor bits match a reference model.
